mul_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the MIPS datapath. It owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Operands come from register-file read ports; the decoder/control issues start_i.
- Multi-cycle with a start/busy/done handshake. The single-cycle ALU cannot do these operations.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_datapath.sv | 79 +++++++
 rtl/mul_div_unit.sv | 128 ++++++++++++
 tb/tb_mul_div_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// the reserved-op check.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULTU = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_DIVU  = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  // Highest defined op code; anything above it is reserved.
  localparam logic [2:0] MDU_OP_MAX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic op_reserved(input logic [2:0] op);
    return op > MDU_OP_MAX;
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Magnitude capture, radix-2 shift-add / restoring shift-subtract iteration
// and sign correction for the multiply/divide unit.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic             signed_op, div_op, neg1, neg2;
  logic [WIDTH:0]   mag1, mag2;
  logic [WIDTH:0]   mag_a, mag_b;
  logic [2*WIDTH:0] acc;
  logic             div_mode, sign_q, sign_r;

  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign div_op    = (op == MDU_DIV) || (op == MDU_DIVU);
  assign neg1      = signed_op & src1[WIDTH-1];
  assign neg2      = signed_op & src2[WIDTH-1];
  // One extra bit keeps |INT_MIN| representable.
  assign mag1 = neg1 ? ({1'b0, ~src1} + (WIDTH+1)'(1)) : {1'b0, src1};
  assign mag2 = neg2 ? ({1'b0, ~src2} + (WIDTH+1)'(1)) : {1'b0, src2};

  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] mul_next;
  assign mul_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? mag_a : '0);
  assign mul_next = {1'b0, mul_sum, acc[WIDTH-1:1]};

  // Remainder lives in the upper half, dividend/quotient in the lower half.
  logic [WIDTH:0]   rem_sh, new_rem;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [2*WIDTH:0] div_next;
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = {1'b0, rem_sh} - {1'b0, mag_b};
  assign ge       = ~diff[WIDTH+1];
  assign new_rem  = ge ? diff[WIDTH:0] : rem_sh;
  assign div_next = {new_rem, acc[WIDTH-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      div_mode <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
    end else if (load) begin
      mag_a    <= mag1;
      mag_b    <= mag2;
      acc      <= {(WIDTH+1)'(0), div_op ? mag1[WIDTH-1:0] : mag2[WIDTH-1:0]};
      div_mode <= div_op;
      sign_q   <= neg1 ^ neg2;
      sign_r   <= neg1;
    end else if (step) begin
      acc <= div_mode ? div_next : mul_next;
    end
  end

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo, rem;
  assign prod     = acc[2*WIDTH-1:0];
  assign prod_fix = sign_q ? -prod : prod;
  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];

  assign hi_res = div_mode ? (sign_r ? -rem : rem) : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_res = div_mode ? (sign_q ? -quo : quo) : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
//   state   | meaning
//   IDLE    | waiting for start_i; MTHI/MTLO and divide-by-zero resolve here
//   RUN     | one shift-add / shift-subtract iteration per cycle, WIDTH cycles
//   FIX     | apply result signs, write HI/LO
//   DONE    | done_o pulse, back to IDLE
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load, step, fix_we, hi_we, lo_we, dz_set, dz_clr, is_div;
  logic [WIDTH-1:0] hi_res, lo_res;

  assign is_div = (op_i == MDU_DIV) || (op_i == MDU_DIVU);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix_we    = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    dz_set    = 1'b0;
    dz_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i && !flush_i && !op_reserved(op_i)) begin
          if (op_i == MDU_MTHI) begin
            hi_we     = 1'b1;
            state_nxt = ST_DONE;
          end else if (op_i == MDU_MTLO) begin
            lo_we     = 1'b1;
            state_nxt = ST_DONE;
          end else if (is_div && (src2_i == '0)) begin
            dz_set    = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            load      = 1'b1;
            dz_clr    = is_div;
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_nxt = ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_LAST) state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        if (flush_i) begin
          state_nxt = ST_IDLE;
        end else begin
          fix_we    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else begin
      if (fix_we) begin
        hi_o <= hi_res;
        lo_o <= lo_res;
      end
      if (hi_we) hi_o <= src1_i;
      if (lo_we) lo_o <= src1_i;
      if (dz_set)      div_zero_o <= 1'b1;
      else if (dz_clr) div_zero_o <= 1'b0;
    end
  end

  assign busy_o = (state != ST_IDLE);
  assign done_o = (state == ST_DONE);

  mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (load),
    .step   (step),
    .op     (op_i),
    .src1   (src1_i),
    .src2   (src2_i),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus flush, reset and
// handshake corner sequences.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] src1_i, src2_i;
  logic             flush_i;
  logic             busy_o, done_o, div_zero_o;
  logic [WIDTH-1:0] hi_o, lo_o;

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } vec_t;

  vec_t vecs[18];

  int busy_cnt, done_cnt, done_cyc;

  // Issue one op and follow it until busy drops. Cycle c is the sample
  // taken after the c-th rising edge counting the issue edge as edge 1.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    @(negedge clk_i);
    start_i = 1'b0; src1_i = ~a; src2_i = 32'h0;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      if (done_o) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (!busy_o) break;
      busy_cnt++;
      @(negedge clk_i);
    end
    check("busy_released", {63'd0, busy_o}, 64'd0);
  endtask

  task automatic run_flush(input int fcyc, input string tag);
    logic [31:0] hi0, lo0;
    logic        seen_done;
    hi0 = hi_o; lo0 = lo_o; seen_done = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1; op_i = MDU_MULTU; src1_i = 32'd3; src2_i = 32'd4;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 1; c <= fcyc; c++) begin
      start_i = (c == 5);
      op_i    = (c == 5) ? MDU_MTHI : MDU_MULTU;
      src1_i  = 32'h5555_5555;
      flush_i = (c == fcyc);
      @(negedge clk_i);
      if (done_o) seen_done = 1'b1;
    end
    start_i = 1'b0; flush_i = 1'b0;
    check({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    @(negedge clk_i);
    if (done_o) seen_done = 1'b1;
    check({tag, "_no_done"}, {63'd0, seen_done}, 64'd0);
    check({tag, "_hi"}, {32'd0, hi_o}, {32'd0, hi0});
    check({tag, "_lo"}, {32'd0, lo_o}, {32'd0, lo0});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
    vecs[1]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34};
    vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[3]  = '{MDU_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 34};
    vecs[4]  = '{MDU_MTHI,  32'h0000_1234, 32'd9,        32'h0000_1234, 32'd14,        1'b0, 1};
    vecs[5]  = '{MDU_DIVU,  32'd5,         32'd0,        32'h0000_1234, 32'd14,        1'b1, 1};
    vecs[6]  = '{MDU_DIV,   32'd8,         32'd2,        32'd0,         32'd4,         1'b0, 34};
    vecs[7]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 34};
    vecs[8]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0, 34};
    vecs[9]  = '{MDU_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, 34};
    vecs[10] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 34};
    vecs[11] = '{MDU_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,        1'b0, 34};
    vecs[12] = '{MDU_MTLO,  32'hDEAD_BEEF, 32'd0,        32'hFFFF_FFFE, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[13] = '{MDU_DIV,   32'd3,         32'd0,        32'hFFFF_FFFE, 32'hDEAD_BEEF, 1'b1, 1};
    vecs[14] = '{MDU_MULTU, 32'd6,         32'd7,        32'd0,         32'd42,        1'b1, 34};
    vecs[15] = '{MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd1,         1'b1, 34};
    vecs[16] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF, 1'b0, 34};
    vecs[17] = '{3'd7,      32'h1111_1111, 32'h2222_2222, 32'hF,        32'h0FFF_FFFF, 1'b0, 0};

    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    op_i = 3'd0; src1_i = '0; src2_i = '0;
    #1;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_dz",   {63'd0, div_zero_o}, 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_hi", i), {32'd0, hi_o}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_lo", i), {32'd0, lo_o}, {32'd0, vecs[i].lo});
      check($sformatf("v%0d_dz", i), {63'd0, div_zero_o}, {63'd0, vecs[i].dz});
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_cnt), 64'(vecs[i].cyc));
      check($sformatf("v%0d_done_cycle", i), 64'(done_cyc), 64'(vecs[i].cyc));
      check($sformatf("v%0d_done_pulses", i), 64'(done_cnt), (vecs[i].cyc != 0) ? 64'd1 : 64'd0);
    end

    // Flush mid-RUN (with a stray start while busy) and flush in FIX.
    run_flush(10, "flush_run");
    run_flush(33, "flush_fix");

    // flush and start together in IDLE: flush wins.
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1; op_i = MDU_MTLO; src1_i = 32'h1234_5678;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    check("idle_flush_busy", {63'd0, busy_o}, 64'd0);
    check("idle_flush_lo", {32'd0, lo_o}, 64'h0FFF_FFFF);

    // start held through DONE is ignored.
    @(negedge clk_i);
    start_i = 1'b1; op_i = MDU_MTHI; src1_i = 32'hABCD_0000;
    @(negedge clk_i);
    check("done_pulse", {63'd0, done_o}, 64'd1);
    op_i = MDU_MTLO; src1_i = 32'h1111_0000;
    @(negedge clk_i);
    start_i = 1'b0;
    check("done_start_busy", {63'd0, busy_o}, 64'd0);
    check("done_start_hi", {32'd0, hi_o}, 64'hABCD_0000);
    check("done_start_lo", {32'd0, lo_o}, 64'h0FFF_FFFF);

    // Asynchronous reset in the middle of RUN.
    run_op(MDU_DIVU, 32'd1, 32'd0);
    check("pre_rst_dz", {63'd0, div_zero_o}, 64'd1);
    @(negedge clk_i);
    start_i = 1'b1; op_i = MDU_MULTU; src1_i = 32'd9; src2_i = 32'd9;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (8) @(negedge clk_i);
    check("pre_rst_busy", {63'd0, busy_o}, 64'd1);
    #2 rst_i = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy_o}, 64'd0);
    check("arst_done", {63'd0, done_o}, 64'd0);
    check("arst_dz",   {63'd0, div_zero_o}, 64'd0);
    check("arst_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_op(MDU_MTLO, 32'hA5A5_A5A5, 32'd0);
    check("post_rst_lo", {32'd0, lo_o}, 64'hA5A5_A5A5);
    check("post_rst_hi", {32'd0, hi_o}, 64'd0);
    check("post_rst_done_cycle", 64'(done_cyc), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
